// File: rtl/vx_commit_arbiter.sv
// Commit stage: round-robin merge of execute-unit results onto one writeback bus; 1-cycle latency.
// Multi-beat results hold a lock on their source so instructions are never interleaved; no wb backpressure.
module vx_commit_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_W      = 44,
  parameter int CTR_W       = 44
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*UUID_W-1:0]         src_uuid,
  input  logic [NUM_SRC*NW_BITS-1:0]        src_wid,
  input  logic [NUM_SRC*NUM_THREADS-1:0]    src_tmask,
  input  logic [NUM_SRC*XLEN-1:0]           src_pc,
  input  logic [NUM_SRC-1:0]                src_wb,
  input  logic [NUM_SRC*NR_BITS-1:0]        src_rd,
  input  logic [NUM_SRC*NUM_THREADS*XLEN-1:0] src_data,
  input  logic [NUM_SRC-1:0]                src_sop,
  input  logic [NUM_SRC-1:0]                src_eop,
  output logic                              wb_valid,
  output logic [UUID_W-1:0]                 wb_uuid,
  output logic [NW_BITS-1:0]                wb_wid,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [XLEN-1:0]                   wb_pc,
  output logic [NR_BITS-1:0]                wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]       wb_data,
  output logic                              wb_sop,
  output logic                              wb_eop,
  output logic                              retire_valid,
  output logic [CTR_W-1:0]                  retire_count
);

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DW = NUM_THREADS * XLEN;

  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [GW-1:0]      lock_id_q, lock_id_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic               retire_q, retire_d;
  logic               wb_valid_q, wb_valid_d;

  logic [NUM_SRC-1:0] grant;
  logic [GW-1:0]      gid;
  logic               found;
  logic               fire;
  int                 idx;
  logic [GW-1:0]      idx_b;

  logic [UUID_W-1:0]      sel_uuid;
  logic [NW_BITS-1:0]     sel_wid;
  logic [NUM_THREADS-1:0] sel_tmask;
  logic [XLEN-1:0]        sel_pc;
  logic [NR_BITS-1:0]     sel_rd;
  logic [DW-1:0]          sel_data;
  logic                   sel_wb, sel_sop, sel_eop;

  logic [UUID_W-1:0]      wb_uuid_q;
  logic [NW_BITS-1:0]     wb_wid_q;
  logic [NUM_THREADS-1:0] wb_tmask_q;
  logic [XLEN-1:0]        wb_pc_q;
  logic [NR_BITS-1:0]     wb_rd_q;
  logic [DW-1:0]          wb_data_q;
  logic                   wb_sop_q, wb_eop_q;

  // Locked source owns the bus even while idle; otherwise scan from rr_ptr with wrap.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    if (lock_q) begin
      if (src_valid[lock_id_q]) begin
        grant[lock_id_q] = 1'b1;
        gid              = lock_id_q;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        idx_b = GW'(idx);
        if (!found && src_valid[idx_b]) begin
          found        = 1'b1;
          gid          = idx_b;
          grant[idx_b] = 1'b1;
        end
      end
    end
    if (!reset_n) grant = '0;
  end

  assign fire      = |grant;
  assign src_ready = grant;

  always_comb begin
    sel_uuid  = '0;
    sel_wid   = '0;
    sel_tmask = '0;
    sel_pc    = '0;
    sel_rd    = '0;
    sel_data  = '0;
    sel_wb    = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant[s]) begin
        sel_uuid  = src_uuid[s*UUID_W +: UUID_W];
        sel_wid   = src_wid[s*NW_BITS +: NW_BITS];
        sel_tmask = src_tmask[s*NUM_THREADS +: NUM_THREADS];
        sel_pc    = src_pc[s*XLEN +: XLEN];
        sel_rd    = src_rd[s*NR_BITS +: NR_BITS];
        sel_data  = src_data[s*DW +: DW];
        sel_wb    = src_wb[s];
        sel_sop   = src_sop[s];
        sel_eop   = src_eop[s];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    cnt_d      = cnt_q;
    retire_d   = fire & sel_eop;
    wb_valid_d = fire & sel_wb;
    if (fire) begin
      rr_ptr_d = (gid == GW'(NUM_SRC - 1)) ? '0 : gid + 1'b1;
      if (sel_eop) begin
        lock_d = 1'b0;
        cnt_d  = cnt_q + 1'b1;
      end else if (sel_sop) begin
        lock_d    = 1'b1;
        lock_id_d = gid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      cnt_q      <= '0;
      retire_q   <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      cnt_q      <= cnt_d;
      retire_q   <= retire_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Payload only moves on fire so it holds the last beat while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_uuid_q  <= '0;
      wb_wid_q   <= '0;
      wb_tmask_q <= '0;
      wb_pc_q    <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_sop_q   <= 1'b0;
      wb_eop_q   <= 1'b0;
    end else if (fire) begin
      wb_uuid_q  <= sel_uuid;
      wb_wid_q   <= sel_wid;
      wb_tmask_q <= sel_tmask;
      wb_pc_q    <= sel_pc;
      wb_rd_q    <= sel_rd;
      wb_data_q  <= sel_data;
      wb_sop_q   <= sel_sop;
      wb_eop_q   <= sel_eop;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_uuid      = wb_uuid_q;
  assign wb_wid       = wb_wid_q;
  assign wb_tmask     = wb_tmask_q;
  assign wb_pc        = wb_pc_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_sop       = wb_sop_q;
  assign wb_eop       = wb_eop_q;
  assign retire_valid = retire_q;
  assign retire_count = cnt_q;

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
  a_eop_needs_sop: assert property (@(posedge clk) disable iff (!reset_n)
    (fire && sel_eop && !sel_sop) |-> lock_q);
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter; a second instance with a 4-bit retire counter checks wrap.
module tb_vx_commit_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   src_valid;
  logic [175:0] src_uuid;
  logic [7:0]   src_wid;
  logic [15:0]  src_tmask;
  logic [127:0] src_pc;
  logic [3:0]   src_wb;
  logic [23:0]  src_rd;
  logic [511:0] src_data;
  logic [3:0]   src_sop;
  logic [3:0]   src_eop;

  logic [3:0]   src_ready;
  logic         wb_valid;
  logic [43:0]  wb_uuid;
  logic [1:0]   wb_wid;
  logic [3:0]   wb_tmask;
  logic [31:0]  wb_pc;
  logic [5:0]   wb_rd;
  logic [127:0] wb_data;
  logic         wb_sop, wb_eop;
  logic         retire_valid;
  logic [43:0]  retire_count;

  logic [3:0]   d4_src_ready;
  logic         d4_wb_valid;
  logic [43:0]  d4_wb_uuid;
  logic [1:0]   d4_wb_wid;
  logic [3:0]   d4_wb_tmask;
  logic [31:0]  d4_wb_pc;
  logic [5:0]   d4_wb_rd;
  logic [127:0] d4_wb_data;
  logic         d4_wb_sop, d4_wb_eop;
  logic         d4_retire_valid;
  logic [3:0]   d4_retire_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [43:0] exp_cnt;

  vx_commit_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_uuid(src_uuid),
    .src_wid(src_wid), .src_tmask(src_tmask), .src_pc(src_pc), .src_wb(src_wb),
    .src_rd(src_rd), .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
    .retire_valid(retire_valid), .retire_count(retire_count)
  );

  vx_commit_arbiter #(.CTR_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(d4_src_ready), .src_uuid(src_uuid),
    .src_wid(src_wid), .src_tmask(src_tmask), .src_pc(src_pc), .src_wb(src_wb),
    .src_rd(src_rd), .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop),
    .wb_valid(d4_wb_valid), .wb_uuid(d4_wb_uuid), .wb_wid(d4_wb_wid), .wb_tmask(d4_wb_tmask),
    .wb_pc(d4_wb_pc), .wb_rd(d4_wb_rd), .wb_data(d4_wb_data), .wb_sop(d4_wb_sop), .wb_eop(d4_wb_eop),
    .retire_valid(d4_retire_valid), .retire_count(d4_retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0; src_uuid = '0; src_wid = '0; src_tmask = '0; src_pc = '0;
    src_wb = '0; src_rd = '0; src_data = '0; src_sop = '0; src_eop = '0;
  endtask

  task automatic set_src(input int s, input logic [43:0] uuid, input logic [1:0] wid,
                         input logic [3:0] tm, input logic [31:0] pc, input logic wb,
                         input logic [5:0] rd, input logic [127:0] data,
                         input logic sop, input logic eop);
    src_valid[s]          = 1'b1;
    src_uuid[s*44 +: 44]  = uuid;
    src_wid[s*2 +: 2]     = wid;
    src_tmask[s*4 +: 4]   = tm;
    src_pc[s*32 +: 32]    = pc;
    src_wb[s]             = wb;
    src_rd[s*6 +: 6]      = rd;
    src_data[s*128 +: 128] = data;
    src_sop[s]            = sop;
    src_eop[s]            = eop;
  endtask

  task automatic test_reset();
    clear_src();
    reset_n = 1'b0;
    src_valid = 4'hF;
    src_sop = 4'hF; src_eop = 4'hF; src_wb = 4'hF;
    #3;
    n_checks++; if (src_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %h exp 0", src_ready); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b exp 0", wb_valid); end
    n_checks++; if (retire_count !== 44'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", retire_count); end
    n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire_valid: got %b exp 0", retire_valid); end
    cyc(); cyc();
    clear_src();
    reset_n = 1'b1;
    exp_cnt = 44'd0;
    cyc();
  endtask

  task automatic test_rr_fairness();
    logic [3:0]  exp_g;
    logic [43:0] exp_u;
    clear_src();
    for (int s = 0; s < 4; s++) set_src(s, 44'(100 + s), 2'd0, 4'hF, 32'h0, 1'b1, 6'd1, 128'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_u = 44'(100 + (k % 4));
      #1;
      n_checks++; if (src_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, src_ready, exp_g); end
      cyc();
      exp_cnt = exp_cnt + 1;
      n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== exp_u) begin n_fail++; $display("FAIL rr_wb[%0d]: got v=%b uuid=%0d exp v=1 uuid=%0d", k, wb_valid, wb_uuid, exp_u); end
    end
    n_checks++; if (retire_count !== 44'd8) begin n_fail++; $display("FAIL rr_count: got %0d exp 8", retire_count); end
    clear_src();
    cyc();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_wb_valid: got %b exp 0", wb_valid); end
  endtask

  task automatic test_lock();
    // Move rr_ptr to 1 with a lone ALU beat.
    clear_src();
    set_src(0, 44'd199, 2'd0, 4'hF, 32'h0, 1'b1, 6'd1, 128'h0, 1'b1, 1'b1);
    cyc(); exp_cnt = exp_cnt + 1;
    clear_src();
    set_src(0, 44'd200, 2'd0, 4'hF, 32'h0, 1'b1, 6'd1, 128'h0, 1'b1, 1'b1);
    set_src(1, 44'd301, 2'd1, 4'hF, 32'h0, 1'b1, 6'd2, 128'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (src_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_sop_grant: got %b exp 0010", src_ready); end
    cyc();
    n_checks++; if (wb_uuid !== 44'd301 || wb_sop !== 1'b1 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL lock_beat0: got uuid=%0d sop=%b ret=%b exp 301/1/0", wb_uuid, wb_sop, retire_valid); end
    set_src(1, 44'd302, 2'd1, 4'hF, 32'h0, 1'b1, 6'd2, 128'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (src_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_mid_grant: got %b exp 0010", src_ready); end
    cyc();
    n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== 44'd302) begin n_fail++; $display("FAIL lock_beat1: got v=%b uuid=%0d exp 1/302", wb_valid, wb_uuid); end
    src_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (src_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_gap_stall[%0d]: got %b exp 0000", k, src_ready); end
      cyc();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lock_gap_wb[%0d]: got %b exp 0", k, wb_valid); end
    end
    set_src(1, 44'd303, 2'd1, 4'hF, 32'h0, 1'b1, 6'd2, 128'h0, 1'b0, 1'b1);
    #1;
    n_checks++; if (src_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_eop_grant: got %b exp 0010", src_ready); end
    cyc(); exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_uuid !== 44'd303 || wb_eop !== 1'b1 || retire_valid !== 1'b1) begin n_fail++; $display("FAIL lock_beat2: got uuid=%0d eop=%b ret=%b exp 303/1/1", wb_uuid, wb_eop, retire_valid); end
    src_valid[1] = 1'b0;
    #1;
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_release_alu: got %b exp 0001", src_ready); end
    cyc(); exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_uuid !== 44'd200 || retire_count !== exp_cnt) begin n_fail++; $display("FAIL lock_alu_after: got uuid=%0d cnt=%0d exp 200/%0d", wb_uuid, retire_count, exp_cnt); end
    clear_src();
  endtask

  task automatic test_wb0();
    clear_src();
    set_src(3, 44'd400, 2'd3, 4'hF, 32'h0, 1'b0, 6'd9, 128'h0, 1'b1, 1'b1);
    #1;
    n_checks++; if (src_ready !== 4'b1000) begin n_fail++; $display("FAIL wb0_ready: got %b exp 1000", src_ready); end
    cyc(); exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_valid !== 1'b0 || retire_valid !== 1'b1) begin n_fail++; $display("FAIL wb0_out: got v=%b ret=%b exp 0/1", wb_valid, retire_valid); end
    n_checks++; if (retire_count !== exp_cnt) begin n_fail++; $display("FAIL wb0_count: got %0d exp %0d", retire_count, exp_cnt); end
    clear_src();
  endtask

  task automatic test_payload();
    logic [127:0] d;
    d = {32'hD, 32'hC, 32'hB, 32'hA};
    clear_src();
    set_src(0, 44'h123_4567_89AB, 2'd2, 4'b1010, 32'h8000_1000, 1'b1, 6'd5, d, 1'b1, 1'b1);
    #1;
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL pay_ready: got %b exp 0001", src_ready); end
    cyc(); exp_cnt = exp_cnt + 1;
    clear_src();
    n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== 44'h123_4567_89AB || wb_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL pay_hdr: got v=%b uuid=%h pc=%h", wb_valid, wb_uuid, wb_pc); end
    n_checks++; if (wb_rd !== 6'd5 || wb_wid !== 2'd2 || wb_tmask !== 4'b1010) begin n_fail++; $display("FAIL pay_ctl: got rd=%0d wid=%0d tm=%b exp 5/2/1010", wb_rd, wb_wid, wb_tmask); end
    n_checks++; if (wb_data !== d || wb_sop !== 1'b1 || wb_eop !== 1'b1) begin n_fail++; $display("FAIL pay_data: got %h exp %h", wb_data, d); end
    cyc();
    n_checks++; if (wb_valid !== 1'b0 || wb_rd !== 6'd5 || wb_data !== d) begin n_fail++; $display("FAIL pay_hold: got v=%b rd=%0d exp 0/5", wb_valid, wb_rd); end
  endtask

  task automatic test_reset_mid_and_wrap();
    clear_src();
    set_src(2, 44'd500, 2'd1, 4'hF, 32'h0, 1'b1, 6'd3, 128'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (src_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_fpu_grant: got %b exp 0100", src_ready); end
    cyc();
    n_checks++; if (wb_uuid !== 44'd500) begin n_fail++; $display("FAIL rm_fpu_wb: got %0d exp 500", wb_uuid); end
    set_src(0, 44'd600, 2'd0, 4'hF, 32'h0, 1'b1, 6'd4, 128'h0, 1'b1, 1'b1);
    set_src(2, 44'd501, 2'd1, 4'hF, 32'h0, 1'b1, 6'd3, 128'h0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_checks++; if (src_ready !== 4'b0000 || wb_valid !== 1'b0 || retire_count !== 44'd0) begin n_fail++; $display("FAIL rm_in_reset: got rdy=%b v=%b cnt=%0d exp 0/0/0", src_ready, wb_valid, retire_count); end
    cyc();
    reset_n = 1'b1;
    exp_cnt = 44'd0;
    #1;
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_alu_first: got %b exp 0001", src_ready); end
    cyc(); exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_uuid !== 44'd600 || retire_count !== 44'd1) begin n_fail++; $display("FAIL rm_alu_wb: got uuid=%0d cnt=%0d exp 600/1", wb_uuid, retire_count); end
    clear_src();
    set_src(0, 44'd700, 2'd0, 4'hF, 32'h0, 1'b1, 6'd4, 128'h0, 1'b1, 1'b1);
    for (int k = 0; k < 14; k++) begin cyc(); exp_cnt = exp_cnt + 1; end
    n_checks++; if (d4_retire_count !== 4'd15 || retire_count !== 44'd15) begin n_fail++; $display("FAIL wrap_pre: got d4=%0d main=%0d exp 15/15", d4_retire_count, retire_count); end
    cyc(); exp_cnt = exp_cnt + 1;
    n_checks++; if (d4_retire_count !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d exp 0", d4_retire_count); end
    n_checks++; if (retire_count !== 44'd16 || retire_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_main: got %0d exp 16", retire_count); end
    clear_src();
    cyc();
  endtask

  initial begin
    clear_src();
    reset_n = 1'b0;
    exp_cnt = 44'd0;
    test_reset();
    test_rr_fairness();
    test_lock();
    test_wb0();
    test_payload();
    test_reset_mid_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
